binary_search_8bit: RTL
=======================

# binary_search_8bit

Successive-approximation search engine that recovers an unknown unsigned value by driving trial values into an external magnitude comparator and consuming its less-than / greater-than / equal flags. It is the initiator end of the comparator interface: the comparator answers "how does trial compare to target", and this block decides what to ask next. It sits beside a combinational comparator whose `a` input is `trial` and whose `b` input is the hidden target.

## Interface
Parameters:
- `WIDTH`, 8, operand width in bits; search takes at most `WIDTH` compare cycles.

Ports:
- `clock`  input  1  single clock; all state changes on rising edge.
- `reset`  input  1  asynchronous, active-low reset; low forces idle state and zeroes all outputs.
- `start`  input  1  request a search; sampled only in IDLE.
- `cmp_lt`  input  1  comparator flag: trial < target.
- `cmp_gt`  input  1  comparator flag: trial > target.
- `cmp_eq`  input  1  comparator flag: trial == target.
- `trial`  output  WIDTH  value presented to comparator `a`.
- `busy`  output  1  high while in SEARCH.
- `done`  output  1  one-cycle pulse, high during DONE.
- `result`  output  WIDTH  recovered target; valid from `done` until next accepted `start`.
- `error`  output  1  flags not one-hot during a compare; held until next accepted `start`.

## Operation
- States: IDLE, SEARCH, DONE. Internal: accumulator `acc` (WIDTH), bit index `k`.
- IDLE: `trial`=0, `busy`=0. `start`=1 at edge -> `acc`=0, `k`=WIDTH-1, `error`=0, go SEARCH.
- SEARCH: `trial` = `acc` | (1<<`k`), combinational from registers. At each edge, with flags sampled:
  - exactly one flag set: `cmp_lt` or `cmp_eq` -> keep bit `k` in `acc`; `cmp_gt` -> leave it clear.
  - `cmp_eq` with early exit enabled -> `result`=`trial`, go DONE immediately.
  - `k`==0 -> `result` = updated `acc`, go DONE; else `k`=`k`-1.
  - zero or multiple flags set -> `error`=1, `result`=0, go DONE.
- DONE: `done`=1, `trial`=0; next edge -> IDLE unconditionally.
- `start` in SEARCH or DONE is ignored (not queued).
- Arithmetic: unsigned only; no carries; `acc` never exceeds target when flags are consistent.
- Reset (any state, including mid-SEARCH): state IDLE; `trial`, `result`, `busy`, `done`, `error`, `acc`, `k` all 0.

## Timing
- Comparator assumed combinational: flags settle within the same cycle `trial` changes.
- `start` sampled at edge E0 -> `busy` high from E0. Full search: DONE entered at edge E(WIDTH), i.e. `done` high in the cycle after the WIDTH-th compare.
- Early exit on compare n (n=1..WIDTH): `done` high after edge En.
- `busy` and `done` never high together. Minimum spacing between accepted starts: DONE cycle plus one IDLE cycle.
- `result` updates only on the DONE transition.

## Configuration
- `BINARY_SEARCH_EARLY_EXIT_EN` defined: `cmp_eq` terminates the search on that compare; latency 1..WIDTH compares.
- Not defined: `cmp_eq` treated as keep-bit only; every search runs exactly WIDTH compares (constant latency). `result` is identical in both builds.

## Test plan
- Target 0xA5, early exit off: trials 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5; `result`=0xA5, `done` 8 edges after start, `error`=0.
- Target 0x80, early exit on: single trial 0x80, `done` after 1 compare, `result`=0x80; off: 8 compares, `result`=0x80.
- Target 0x00 and 0xFF: `result`=0x00 (all `cmp_gt`) and 0xFF (last trial 0xFF, eq) respectively; no `error`.
- Force `cmp_lt`=`cmp_gt`=1 on third compare: `error`=1, `result`=0, `done` pulses next cycle; `error` clears on next accepted `start`.
- Pulse `start` during SEARCH: ignored, search for 0x3C completes unaffected with `result`=0x3C.
- Assert `reset` low mid-SEARCH: all outputs 0 immediately (asynchronous); after release, new `start` with target 0x5A yields `result`=0x5A.

Source files
------------

// File: rtl/binary_search_8bit_if.sv
// Comparator-side bundle for binary_search_8bit.
// master: the search engine (drives trial/status, consumes start and flags).
// slave : the environment (drives start and comparator flags, observes results).
interface binary_search_8bit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             cmp_lt;
    logic             cmp_gt;
    logic             cmp_eq;
    logic [WIDTH-1:0] trial;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             error;

    modport master (
        input  start, cmp_lt, cmp_gt, cmp_eq,
        output trial, busy, done, result, error
    );

    modport slave (
        output start, cmp_lt, cmp_gt, cmp_eq,
        input  trial, busy, done, result, error
    );
endinterface

// File: rtl/binary_search_8bit.sv
// Successive-approximation search engine driving an external magnitude
// comparator. Each SEARCH cycle presents acc | (1<<k) as the trial and keeps
// or drops bit k depending on the comparator answer.
// Optional feature macro: BINARY_SEARCH_EARLY_EXIT_EN -- when defined, an
// equal answer ends the search on that compare; otherwise every search runs
// exactly WIDTH compares.
module binary_search_8bit #(
    parameter int WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    binary_search_8bit_if.master   bus
);
    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [KW-1:0]    k_q, k_d;
    logic             error_q, error_d;

    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] trial_w;
    logic [WIDTH-1:0] acc_upd;
    logic             one_hot;
    logic             keep_bit;
    logic             early_exit;

    // Datapath helpers: current trial bit, trial value and the accumulator
    // as it would look after this compare.
    always_comb begin
        bit_mask = {{(WIDTH-1){1'b0}}, 1'b1} << k_q;
        trial_w  = (state_q == SEARCH) ? (acc_q | bit_mask) : '0;
        one_hot  = ({bus.cmp_lt, bus.cmp_gt, bus.cmp_eq} == 3'b100) ||
                   ({bus.cmp_lt, bus.cmp_gt, bus.cmp_eq} == 3'b010) ||
                   ({bus.cmp_lt, bus.cmp_gt, bus.cmp_eq} == 3'b001);
        // trial <= target means the target has this bit set
        keep_bit = bus.cmp_lt | bus.cmp_eq;
        acc_upd  = keep_bit ? (acc_q | bit_mask) : acc_q;
`ifdef BINARY_SEARCH_EARLY_EXIT_EN
        early_exit = bus.cmp_eq;
`else
        early_exit = 1'b0;
`endif
    end

    // Next-state and register-update logic for the search FSM.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        result_d = result_q;
        k_d      = k_q;
        error_d  = error_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d   = '0;
                    k_d     = KW'(WIDTH - 1);
                    error_d = 1'b0;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (!one_hot) begin
                    // Inconsistent comparator answer: abandon with a flagged zero.
                    error_d  = 1'b1;
                    result_d = '0;
                    state_d  = DONE;
                end else begin
                    acc_d = acc_upd;
                    if (early_exit) begin
                        result_d = trial_w;
                        state_d  = DONE;
                    end else if (k_q == '0) begin
                        result_d = acc_upd;
                        state_d  = DONE;
                    end else begin
                        k_d = k_q - 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            result_q <= '0;
            k_q      <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            k_q      <= k_d;
            error_q  <= error_d;
        end
    end

    // Outputs are decoded from registers only, so reset zeroes them at once.
    always_comb begin
        bus.trial  = trial_w;
        bus.busy   = (state_q == SEARCH);
        bus.done   = (state_q == DONE);
        bus.result = result_q;
        bus.error  = error_q;
    end
endmodule
